// File: rtl/uart2rah_packer.sv
// Packs UART receiver bytes into RAH-width packets, first byte in the most-significant slot.
// A partial packet goes out on flush or after TIMEOUT_CLKS idle clocks.
module uart2rah_packer #(
   parameter int RAH_PACKET_WIDTH = 48,
   parameter int BYTES_IN_PACKET  = RAH_PACKET_WIDTH / 8,
   parameter int UART_DATA_WIDTH  = 8,
   parameter int TIMEOUT_CLKS     = 18720
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 rx_dv,
   input  logic [UART_DATA_WIDTH-1:0]           rx_byte,
   input  logic                                 flush,
   output logic [RAH_PACKET_WIDTH-1:0]          tx_data,
   output logic                                 send_data,
   output logic [$clog2(BYTES_IN_PACKET):0]     byte_count,
   output logic                                 busy
);

   localparam int W  = RAH_PACKET_WIDTH;
   localparam int U  = UART_DATA_WIDTH;
   localparam int B  = BYTES_IN_PACKET;
   localparam int CW = $clog2(B) + 1;
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] FULL  = CW'(B);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

   state_t          state;
   logic [W-1:0]    pack_q;
   logic [CW-1:0]   cnt;
   logic [TW-1:0]   timer;
   logic [CW-1:0]   cnt_inc;
   logic [W-1:0]    pack_ins;
   logic [W-1:0]    first_pkt;

   assign cnt_inc = cnt + CW'(1);

   // pack_ins: current packet with rx_byte dropped into slot cnt
   always_comb begin
      pack_ins = pack_q;
      for (int k = 0; k < B; k++) begin
         if (CW'(k) == cnt) pack_ins[(B-1-k)*U +: U] = rx_byte;
      end
   end

   always_comb begin
      first_pkt = '0;
      first_pkt[W-1 -: U] = rx_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pack_q     <= '0;
         cnt        <= '0;
         timer      <= '0;
         send_data  <= 1'b0;
         tx_data    <= '0;
         byte_count <= '0;
         busy       <= 1'b0;
      end else begin
         send_data <= 1'b0;
         case (state)
            IDLE: begin
               timer <= '0;
               if (rx_dv) begin
                  pack_q <= first_pkt;
                  cnt    <= CW'(1);
                  busy   <= 1'b1;
                  if (FULL == CW'(1)) begin
                     send_data  <= 1'b1;
                     tx_data    <= first_pkt;
                     byte_count <= CW'(1);
                     state      <= EMIT;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            FILL: begin
               if (rx_dv && cnt != FULL) begin
                  pack_q <= pack_ins;
                  cnt    <= cnt_inc;
                  timer  <= '0;
                  if (cnt_inc == FULL || flush) begin
                     send_data  <= 1'b1;
                     tx_data    <= pack_ins;
                     byte_count <= cnt_inc;
                     state      <= EMIT;
                  end
               end else if (flush || timer == TLAST || cnt == FULL) begin
                  // cnt == FULL only arises with single-byte packets re-entering FILL
                  send_data  <= 1'b1;
                  tx_data    <= pack_q;
                  byte_count <= cnt;
                  state      <= EMIT;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            EMIT: begin
               timer <= '0;
               if (rx_dv) begin
                  pack_q <= first_pkt;
                  cnt    <= CW'(1);
                  busy   <= 1'b1;
                  state  <= FILL;
               end else begin
                  pack_q <= '0;
                  cnt    <= '0;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart2rah_packer.sv
// Randomized and directed bench for uart2rah_packer against a queue-based packet model.
module tb_uart2rah_packer;

   localparam int W = 48;
   localparam int B = W / 8;
   localparam int T = 16;
   localparam int CW = $clog2(B) + 1;

   logic          clk;
   logic          rst;
   logic          rx_dv;
   logic [7:0]    rx_byte;
   logic          flush;
   logic [W-1:0]  tx_data;
   logic          send_data;
   logic [CW-1:0] byte_count;
   logic          busy;

   uart2rah_packer #(.RAH_PACKET_WIDTH(W), .TIMEOUT_CLKS(T)) dut (
      .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte), .flush(flush),
      .tx_data(tx_data), .send_data(send_data), .byte_count(byte_count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: pending bytes in a queue, emission decided from packet rules
   logic [7:0]    byte_q[$];
   int            cyc = 0;
   int            last_cyc = 0;
   bit            in_emit = 0;
   logic          exp_send = 0;
   logic [W-1:0]  exp_tx = '0;
   logic [CW-1:0] exp_cnt = '0;
   logic          exp_busy = 0;

   int            pulses = 0;
   logic [W-1:0]  got_tx;
   logic [CW-1:0] got_cnt;

   function automatic logic [W-1:0] pack_bytes();
      logic [W-1:0] p = '0;
      for (int i = 0; i < byte_q.size(); i++) p[(B-1-i)*8 +: 8] = byte_q[i];
      return p;
   endfunction

   task automatic model_emit();
      exp_send = 1'b1;
      exp_tx   = pack_bytes();
      exp_cnt  = CW'(byte_q.size());
      byte_q.delete();
      in_emit  = 1'b1;
   endtask

   task automatic model_update(input logic dv, input logic [7:0] b, input logic fl, input logic r);
      bit had;
      cyc++;
      exp_send = 1'b0;
      if (r) begin
         byte_q.delete();
         in_emit = 1'b0;
         exp_tx  = '0;
         exp_cnt = '0;
      end else if (in_emit) begin
         in_emit = 1'b0;
         if (dv) begin
            byte_q.push_back(b);
            last_cyc = cyc;
         end
      end else if (dv) begin
         had = byte_q.size() > 0;
         byte_q.push_back(b);
         last_cyc = cyc;
         if (byte_q.size() == B || (fl && had)) model_emit();
      end else if (byte_q.size() > 0 && (fl || cyc - last_cyc == T)) begin
         model_emit();
      end
      exp_busy = (byte_q.size() > 0) || in_emit;
   endtask

   task automatic step(input logic dv, input logic [7:0] b, input logic fl, input logic r);
      rx_dv = dv; rx_byte = b; flush = fl; rst = r;
      @(posedge clk);
      model_update(dv, b, fl, r);
      #1;
      check("send_data", 64'(send_data), 64'(exp_send));
      check("tx_data", 64'(tx_data), 64'(exp_tx));
      check("byte_count", 64'(byte_count), 64'(exp_cnt));
      check("busy", 64'(busy), 64'(exp_busy));
      if (send_data === 1'b1) begin
         pulses++;
         got_tx  = tx_data;
         got_cnt = byte_count;
      end
      rx_dv = 1'b0; flush = 1'b0; rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      step(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      rx_dv = 1'b0; rx_byte = '0; flush = 1'b0; rst = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("reset_outputs", {tx_data, 4'(byte_count), send_data, busy}, 64'd0);

      // Full packet
      pulses = 0;
      for (int i = 1; i <= 6; i++) send_byte(8'(i * 8'h11));
      idle(3);
      check("full_pulses", 64'(pulses), 64'd1);
      check("full_tx", 64'(got_tx), 64'h112233445566);
      check("full_cnt", 64'(got_cnt), 64'd6);
      check("full_busy_after", 64'(busy), 64'd0);

      // Timeout on partial packet
      pulses = 0;
      send_byte(8'hAA); send_byte(8'hBB);
      idle(T + 3);
      check("tmo_pulses", 64'(pulses), 64'd1);
      check("tmo_tx", 64'(got_tx), 64'hAABB00000000);
      check("tmo_cnt", 64'(got_cnt), 64'd2);

      // Byte late in the idle window restarts the timer
      pulses = 0;
      send_byte(8'hAA); send_byte(8'hBB);
      idle(14);
      send_byte(8'hCC);
      idle(T - 2);
      check("tmo_restart_pulses", 64'(pulses), 64'd0);
      idle(4);
      check("tmo_restart_tx", 64'(got_tx), 64'hAABBCC000000);

      // Flush of a partial packet, then flush while idle
      pulses = 0;
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      idle(2);
      check("flush_tx", 64'(got_tx), 64'h010203000000);
      check("flush_cnt", 64'(got_cnt), 64'd3);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      idle(2);
      check("flush_idle_pulses", 64'(pulses), 64'd1);

      // Flush coincident with a byte
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      step(1'b1, 8'h04, 1'b1, 1'b0);
      idle(2);
      check("flush_byte_tx", 64'(got_tx), 64'h010203040000);
      check("flush_byte_cnt", 64'(got_cnt), 64'd4);

      // Byte arriving in the emit cycle starts the next packet
      pulses = 0;
      for (int i = 1; i <= 6; i++) send_byte(8'(i * 8'h11));
      send_byte(8'h77);
      check("emit_first_tx", 64'(got_tx), 64'h112233445566);
      send_byte(8'h88); send_byte(8'h99); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      idle(2);
      check("emit_pulses", 64'(pulses), 64'd2);
      check("emit_second_tx", 64'(got_tx), 64'h778899AABBCC);

      // Reset discards a partial packet
      pulses = 0;
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("rst_outputs", {tx_data, 4'(byte_count), send_data, busy}, 64'd0);
      for (int i = 1; i <= 6; i++) send_byte(8'(8'hF0 + i));
      idle(T + 3);
      check("rst_pulses", 64'(pulses), 64'd1);
      check("rst_tx", 64'(got_tx), 64'hF1F2F3F4F5F6);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            idle($urandom_range(1, T + 4));
         end else begin
            step(1'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 199) == 0));
         end
      end
      idle(T + 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
